freq_input_feeder: RTL
======================

# freq_input_feeder

Write-side controller for the per-channel two-entry input buffer of the sorting tree. It takes a per-channel beat count from the host, issues memory read requests round-robin to channels that have buffer space, and converts tagged read responses into `enq`/`enq_idx`/`din` writes into the buffer. It mirrors the buffer's `deq`/`deq_idx` to return credits, so a response always finds a free entry.

## Interface
- `C_LOG`, default 5: log2 of the channel count; 32 channels.
- `FIFO_WIDTH`, default 1024: beat width, `DATW<<P_LOG`.
- `LEN_W`, default 32: width of the per-channel beat counter.
- `CLK` input, 1 bit: clock; all state on its rising edge.
- `RST` input, 1 bit: asynchronous, active-low reset.
- `cfg_we` input, 1 bit: load the beat count for one channel.
- `cfg_idx` input, `C_LOG` bits: channel to load.
- `cfg_len` input, `LEN_W` bits: number of beats to fetch.
- `rd_req` output, 1 bit: read request valid (registered).
- `rd_idx` output, `C_LOG` bits: channel tag of the request.
- `rd_rdy` input, 1 bit: memory accepts the request this cycle.
- `rsp_valid` input, 1 bit: read response beat valid.
- `rsp_idx` input, `C_LOG` bits: channel tag of the response.
- `rsp_data` input, `FIFO_WIDTH` bits: response beat.
- `deq` input, 1 bit: buffer dequeue, mirrored from the buffer's consumer.
- `deq_idx` input, `C_LOG` bits: channel dequeued.
- `enq` output, 1 bit: buffer write.
- `enq_idx` output, `C_LOG` bits: buffer write channel.
- `din` output, `FIFO_WIDTH` bits: buffer write data.
- `done` output, `1<<C_LOG` bits: per channel, no beats left and none in flight.
- `err` output, 1 bit: sticky protocol-violation flag.

## Operation
- **Per-channel state:**
  - `rem[c]` (`LEN_W` bits): beats not yet requested.
  - `cred[c]` (0..2): buffer entries neither occupied nor reserved.
  - `infl[c]` (0..2): requests issued with no response yet.
- **Reset:** `rem`=0, `cred`=2, `infl`=0, RR pointer=0. Outputs: `rd_req`=0, `rd_idx`=0, `enq`=0, `enq_idx`=0, `din`=0, `done`=all ones, `err`=0.
- **Config:**
  - `cfg_we` with `done[cfg_idx]`=1 and `cfg_len`≠0 sets `rem[cfg_idx]`=`cfg_len`.
  - `cfg_len`=0 is ignored.
  - `cfg_we` while `done[cfg_idx]`=0 is ignored and sets `err`.
- **Eligibility:** channel c is eligible when `rem[c]`≠0 and `cred[c]`≠0.
- **Request FSM:**
  - IDLE: if any channel is eligible, pick the first one at or after the RR pointer (wrapping 31→0). Register `rd_req`=1 and `rd_idx`, then go to REQ.
  - REQ: hold `rd_req` and `rd_idx` stable until `rd_rdy`=1.
  - On acceptance: `rem`−1, `cred`−1, `infl`+1 for that channel; RR pointer = `rd_idx`+1; go to IDLE.
  - Result: at most one accepted request every 2 cycles.
- **Response:** on `rsp_valid`, register `enq`=1, `enq_idx`=`rsp_idx`, `din`=`rsp_data`, and decrement `infl[rsp_idx]`. Responses are always accepted; there is no backpressure.
- **Credit return:** on `deq`, increment `cred[deq_idx]`.
- **Simultaneous events on one channel:**
  - Acceptance and `deq` together: `cred` net unchanged.
  - Acceptance and response together: `infl` net unchanged.
- **Error cases (each sets `err`):**
  - `deq` with `cred`=2: `cred` saturates at 2.
  - `rsp_valid` with `infl`=0: the beat is still written to the buffer, `infl` stays at 0.
- **`done[c]`:** (`rem[c]`==0 && `infl[c]`==0), registered.

## Timing
- `rd_req` rises 1 cycle after a channel becomes eligible, when the FSM is in IDLE.
- Response to `enq`: exactly 1 cycle. `enq` may assert every cycle.
- A `deq` in cycle t makes the channel eligible for arbitration in t+1, so `rd_req` can appear in t+2.
- `done` updates 1 cycle after the last response.
- **Asynchronous reset mid-transfer:** all counters, the pointer and the outputs return to reset values immediately; in-flight responses arriving after reset release set `err`.

## Test plan
- **Single channel:** `cfg_we` idx=3 len=5, `rd_rdy`=1, responses 4 cycles later, no `deq`. Expect exactly 2 requests tagged 3, then stall; 2 `enq` idx=3 with matching `din`; `done[3]`=0.
- **Credit return:** continue the previous case with one `deq` idx=3 per cycle. Expect all 5 beats fetched, `rem[3]`→0, `done[3]`=1 one cycle after the 5th response, and exactly 5 `enq`.
- **Round-robin:** load channels 0, 7 and 31 with len=2 each. Expect request order 0, 7, 31, 0, 7, 31 (wrap 31→0), paced by credits.
- **Backpressure:** hold `rd_rdy`=0 for 10 cycles. Expect `rd_req`/`rd_idx` stable throughout; counters change only on the accepting cycle.
- **Simultaneous events:** same-cycle acceptance and `deq` on channel 5 leave `cred[5]` unchanged. `deq` at `cred`=2 sets `err`. `cfg_we` on a busy channel sets `err` and leaves `rem` unchanged.
- **Reset mid-transfer:** assert `RST`=0 mid-transfer. Expect immediate `rd_req`=0, `enq`=0, `done`=all ones, `cred`=2 for all channels.

Source files
------------

// File: rtl/freq_input_feeder.sv
// Write-side controller for the per-channel two-entry sorter input buffer.
// Issues round-robin memory reads against buffer credits and turns tagged responses into buffer writes.
module freq_input_feeder #(
   parameter int C_LOG      = 5,
   parameter int FIFO_WIDTH = 1024,
   parameter int LEN_W      = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  cfg_we,
   input  logic [C_LOG-1:0]      cfg_idx,
   input  logic [LEN_W-1:0]      cfg_len,
   output logic                  rd_req,
   output logic [C_LOG-1:0]      rd_idx,
   input  logic                  rd_rdy,
   input  logic                  rsp_valid,
   input  logic [C_LOG-1:0]      rsp_idx,
   input  logic [FIFO_WIDTH-1:0] rsp_data,
   input  logic                  deq,
   input  logic [C_LOG-1:0]      deq_idx,
   output logic                  enq,
   output logic [C_LOG-1:0]      enq_idx,
   output logic [FIFO_WIDTH-1:0] din,
   output logic [(1<<C_LOG)-1:0] done,
   output logic                  err
);

   localparam int N = 1 << C_LOG;

   typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic                    rd_req_q, rd_req_d;
   logic [C_LOG-1:0]        rd_idx_q, rd_idx_d;
   logic [C_LOG-1:0]        rr_q, rr_d;
   logic                    enq_q, enq_d;
   logic [C_LOG-1:0]        enq_idx_q, enq_idx_d;
   logic [FIFO_WIDTH-1:0]   din_q, din_d;
   logic [N-1:0]            done_q, done_d;
   logic                    err_q, err_d;
   logic [LEN_W-1:0]        rem_q [N];
   logic [LEN_W-1:0]        rem_d [N];
   logic [1:0]              cred_q [N];
   logic [1:0]              cred_d [N];
   logic [1:0]              infl_q [N];
   logic [1:0]              infl_d [N];

   logic [N-1:0]            elig;
   logic                    accept;
   logic                    pick_vld;
   logic [C_LOG-1:0]        pick_idx;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_elig
         assign elig[gi] = (rem_q[gi] != '0) && (cred_q[gi] != 2'd0);
      end
   endgenerate

   assign accept = (state_q == S_REQ) && rd_rdy;

   // First eligible channel at or after the pointer; the index wraps naturally.
   always_comb begin
      logic [C_LOG-1:0] cand;
      cand     = '0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = 0; k < N; k++) begin
         cand = rr_q + C_LOG'(k);
         if (!pick_vld && elig[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rd_req_d = rd_req_q;
      rd_idx_d = rd_idx_q;
      rr_d     = rr_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               state_d  = S_REQ;
               rd_req_d = 1'b1;
               rd_idx_d = pick_idx;
            end
         end
         S_REQ: begin
            if (rd_rdy) begin
               state_d  = S_IDLE;
               rd_req_d = 1'b0;
               rr_d     = rd_idx_q + C_LOG'(1);
            end
         end
      endcase
   end

   // Per-channel counters: acceptance is applied before the credit return and
   // after the response, so same-cycle pairs cancel without a false error.
   always_comb begin
      logic       acc_c, deq_c, rsp_c;
      logic [1:0] c_tmp, i_tmp;
      acc_c = 1'b0;
      deq_c = 1'b0;
      rsp_c = 1'b0;
      c_tmp = '0;
      i_tmp = '0;
      err_d = err_q;
      for (int c = 0; c < N; c++) begin
         acc_c = accept && (rd_idx_q == C_LOG'(c));
         deq_c = deq && (deq_idx == C_LOG'(c));
         rsp_c = rsp_valid && (rsp_idx == C_LOG'(c));

         rem_d[c] = rem_q[c];
         if (cfg_we && (cfg_idx == C_LOG'(c)) && done_q[c] && (cfg_len != '0)) begin
            rem_d[c] = cfg_len;
         end else if (acc_c) begin
            rem_d[c] = rem_q[c] - LEN_W'(1);
         end

         c_tmp = cred_q[c];
         if (acc_c) c_tmp = c_tmp - 2'd1;
         if (deq_c) begin
            if (c_tmp == 2'd2) err_d = 1'b1;
            else               c_tmp = c_tmp + 2'd1;
         end
         cred_d[c] = c_tmp;

         i_tmp = infl_q[c];
         if (rsp_c) begin
            if (i_tmp == 2'd0) err_d = 1'b1;
            else               i_tmp = i_tmp - 2'd1;
         end
         if (acc_c) i_tmp = i_tmp + 2'd1;
         infl_d[c] = i_tmp;

         done_d[c] = (rem_d[c] == '0) && (i_tmp == 2'd0);
      end
      if (cfg_we && !done_q[cfg_idx]) err_d = 1'b1;
   end

   always_comb begin
      enq_d     = rsp_valid;
      enq_idx_d = enq_idx_q;
      din_d     = din_q;
      if (rsp_valid) begin
         enq_idx_d = rsp_idx;
         din_d     = rsp_data;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         rd_req_q  <= 1'b0;
         rd_idx_q  <= '0;
         rr_q      <= '0;
         enq_q     <= 1'b0;
         enq_idx_q <= '0;
         din_q     <= '0;
         done_q    <= '1;
         err_q     <= 1'b0;
         for (int c = 0; c < N; c++) begin
            rem_q[c]  <= '0;
            cred_q[c] <= 2'd2;
            infl_q[c] <= 2'd0;
         end
      end else begin
         state_q   <= state_d;
         rd_req_q  <= rd_req_d;
         rd_idx_q  <= rd_idx_d;
         rr_q      <= rr_d;
         enq_q     <= enq_d;
         enq_idx_q <= enq_idx_d;
         din_q     <= din_d;
         done_q    <= done_d;
         err_q     <= err_d;
         for (int c = 0; c < N; c++) begin
            rem_q[c]  <= rem_d[c];
            cred_q[c] <= cred_d[c];
            infl_q[c] <= infl_d[c];
         end
      end
   end

   assign rd_req  = rd_req_q;
   assign rd_idx  = rd_idx_q;
   assign enq     = enq_q;
   assign enq_idx = enq_idx_q;
   assign din     = din_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule
